gemv_tile_sched: RTL and testbench
==================================

// Module: gemv_tile_sched
// PURPOSE
//  Sequences the 16x16 GEMV engine over a job of N weight tiles.
//  Per tile: pulses GEMV start, streams 16 weight rows, streams 16 x rows, drains 16 output rows.
//  Sits between the DMA-side row streams and the GEMV qw/qx/qo ports; all row data passes through combinationally.
//  Also generates row indices, counts tiles, flags output-index mismatches and signals job completion.
// PARAMETERS
//  MATRIX_SIZE  16  rows per tile (= GEMV MATRIX_SIZE)
//  BW_IN_DATA   32  bits per element; row width RW = MATRIX_SIZE*BW_IN_DATA
//  TILE_W        8  width of tile-count config/counters
//  INDEX_W      clog2(MATRIX_SIZE+1)  row index width
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  cfg_valid_i  in   1        job request
//  cfg_ready_o  out  1        high only in IDLE
//  cfg_ntiles_i in   TILE_W   tiles in job, sampled on cfg handshake
//  busy_o       out  1        state != IDLE
//  done_o       out  1        1-cycle pulse at job end
//  err_o        out  1        sticky: qo index mismatch seen
//  tile_cnt_o   out  TILE_W   current tile number
//  src_w_valid_i/src_w_ready_o/src_w_data_i[RW]  in/out/in  weight-row stream
//  src_x_valid_i/src_x_ready_o/src_x_data_i[RW]  in/out/in  x-row stream
//  dst_valid_o/dst_ready_i/dst_data_o[RW]        out/in/out result-row stream
//  dst_index_o  out  INDEX_W  row index in tile; dst_tile_o out TILE_W; dst_last_o out 1 last row of job
//  g_start_o    out  1        GEMV start pulse
//  g_qw_valid_o/g_qw_ready_i/g_qw_data_o[RW]/g_qw_index_o[INDEX_W]  GEMV weight port
//  g_qx_valid_o/g_qx_ready_i/g_qx_data_o[RW]/g_qx_index_o[INDEX_W]  GEMV x port
//  g_qo_valid_i/g_qo_ready_o/g_qo_data_i[RW]/g_qo_index_i[INDEX_W]  GEMV output port
// BEHAVIOUR
//  Reset: state=IDLE; all counters, err_o and done_o = 0; every valid and g_start_o = 0; cfg_ready_o = 1.
//  Reset wins over any in-flight transfer. The GEMV must be reset with the scheduler.
//  States: IDLE, START, LOAD_W, FEED_X, DRAIN, NEXT.
//  IDLE: on cfg handshake, latch ntiles and clear tile_cnt.
//   - ntiles==0: done_o pulses next cycle; stays IDLE; no g_start_o.
//   - otherwise -> START.
//  START: g_start_o=1 for exactly this cycle; -> LOAD_W.
//  LOAD_W:
//   - g_qw_valid_o = src_w_valid_i; src_w_ready_o = g_qw_ready_i; g_qw_index_o = w_cnt.
//   - Each handshake increments w_cnt; handshake at w_cnt==MATRIX_SIZE-1 -> FEED_X, w_cnt=0.
//  FEED_X:
//   - Same passthrough on x with x_cnt. src_x_ready_o is 0 once x_cnt reaches MATRIX_SIZE.
//   - -> DRAIN when MATRIX_SIZE x rows are sent; the GEMV pipeline latency is absorbed in DRAIN.
//  DRAIN:
//   - dst_valid_o = g_qo_valid_i; g_qo_ready_o = dst_ready_i.
//   - dst_index_o = o_cnt; dst_tile_o = tile_cnt.
//   - dst_last_o = (o_cnt==MATRIX_SIZE-1) && (tile_cnt==ntiles-1).
//   - On handshake, if g_qo_index_i != o_cnt, set err_o. Data still passes; err_o clears only on rst.
//   - Handshake at o_cnt==MATRIX_SIZE-1 -> NEXT, o_cnt=0.
//  NEXT (1 cycle):
//   - tile_cnt==ntiles-1: -> IDLE, done_o=1 this cycle.
//   - else tile_cnt+1, -> START.
//  Outside its state, each passthrough drives valid=0 and ready=0; data/index outputs are don't-care.
//  cfg_valid_i while busy is not accepted (cfg_ready_o=0) and is held off by the requester.
//  Stalls: any valid/ready may drop on any cycle; counters move only on handshakes.
//  Counter widths: tile_cnt wraps never (bounded by ntiles <= 2^TILE_W-1).
//  Job latency with no stalls: 1 + ntiles*(1+16+16+D+16+1) cycles, D = GEMV drain delay.
// TESTING
//  rst, cfg ntiles=1, streams always valid/ready -> exactly one g_start_o; 16 qw idx 0..15; 16 qx idx 0..15.
//   Then 16 dst rows, idx 0..15, dst_last_o on idx 15, done_o pulse, busy_o=0.
//  ntiles=3 -> three g_start_o pulses; dst_tile_o 0,1,2; 48 dst rows; one done_o.
//  ntiles=0 -> done_o one cycle after handshake; no g_start_o; no stream traffic.
//  Random valid/ready gaps (50%) on all streams, ntiles=2 -> no rows lost or duplicated; indices contiguous.
//  Model qo returns index 5 as 6 -> err_o=1 from that handshake on; job still completes; done_o pulses.
//  rst asserted mid-DRAIN of tile 1 -> next cycle IDLE; all valids 0; a fresh ntiles=1 job completes normally.

Source files
------------

// File: rtl/gemv_tile_sched.sv
// Tile scheduler for the 16x16 GEMV engine: per tile it starts the engine, streams
// weight rows, then x rows, then drains output rows, tagging each with index and tile.
module gemv_tile_sched #(
  parameter int MATRIX_SIZE = 16,
  parameter int BW_IN_DATA  = 32,
  parameter int TILE_W      = 8,
  parameter int INDEX_W     = $clog2(MATRIX_SIZE + 1),
  parameter int RW          = MATRIX_SIZE * BW_IN_DATA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [TILE_W-1:0]  cfg_ntiles_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [TILE_W-1:0]  tile_cnt_o,
  input  logic               src_w_valid_i,
  output logic               src_w_ready_o,
  input  logic [RW-1:0]      src_w_data_i,
  input  logic               src_x_valid_i,
  output logic               src_x_ready_o,
  input  logic [RW-1:0]      src_x_data_i,
  output logic               dst_valid_o,
  input  logic               dst_ready_i,
  output logic [RW-1:0]      dst_data_o,
  output logic [INDEX_W-1:0] dst_index_o,
  output logic [TILE_W-1:0]  dst_tile_o,
  output logic               dst_last_o,
  output logic               g_start_o,
  output logic               g_qw_valid_o,
  input  logic               g_qw_ready_i,
  output logic [RW-1:0]      g_qw_data_o,
  output logic [INDEX_W-1:0] g_qw_index_o,
  output logic               g_qx_valid_o,
  input  logic               g_qx_ready_i,
  output logic [RW-1:0]      g_qx_data_o,
  output logic [INDEX_W-1:0] g_qx_index_o,
  input  logic               g_qo_valid_i,
  output logic               g_qo_ready_o,
  input  logic [RW-1:0]      g_qo_data_i,
  input  logic [INDEX_W-1:0] g_qo_index_i
);

  typedef enum logic [2:0] {IDLE, START, LOAD_W, FEED_X, DRAIN, NEXT} state_t;

  localparam logic [INDEX_W-1:0] LAST_ROW = INDEX_W'(MATRIX_SIZE - 1);
  localparam logic [INDEX_W-1:0] ROWS     = INDEX_W'(MATRIX_SIZE);

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   ntiles_q, ntiles_d;
  logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d;
  logic [INDEX_W-1:0]  w_cnt_q, w_cnt_d;
  logic [INDEX_W-1:0]  x_cnt_q, x_cnt_d;
  logic [INDEX_W-1:0]  o_cnt_q, o_cnt_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                last_tile;
  logic                x_open;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ntiles_q   <= '0;
      tile_cnt_q <= '0;
      w_cnt_q    <= '0;
      x_cnt_q    <= '0;
      o_cnt_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ntiles_q   <= ntiles_d;
      tile_cnt_q <= tile_cnt_d;
      w_cnt_q    <= w_cnt_d;
      x_cnt_q    <= x_cnt_d;
      o_cnt_q    <= o_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign last_tile  = (tile_cnt_q == ntiles_q - TILE_W'(1));
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign tile_cnt_o = tile_cnt_q;

  always_comb begin
    state_d       = state_q;
    ntiles_d      = ntiles_q;
    tile_cnt_d    = tile_cnt_q;
    w_cnt_d       = w_cnt_q;
    x_cnt_d       = x_cnt_q;
    o_cnt_d       = o_cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    done_o        = done_q;
    cfg_ready_o   = 1'b0;
    g_start_o     = 1'b0;
    x_open        = 1'b0;
    src_w_ready_o = 1'b0;
    g_qw_valid_o  = 1'b0;
    g_qw_data_o   = src_w_data_i;
    g_qw_index_o  = w_cnt_q;
    src_x_ready_o = 1'b0;
    g_qx_valid_o  = 1'b0;
    g_qx_data_o   = src_x_data_i;
    g_qx_index_o  = x_cnt_q;
    dst_valid_o   = 1'b0;
    g_qo_ready_o  = 1'b0;
    dst_data_o    = g_qo_data_i;
    dst_index_o   = o_cnt_q;
    dst_tile_o    = tile_cnt_q;
    dst_last_o    = 1'b0;

    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          ntiles_d   = cfg_ntiles_i;
          tile_cnt_d = '0;
          // An empty job completes without touching the engine.
          if (cfg_ntiles_i == '0) done_d = 1'b1;
          else                    state_d = START;
        end
      end
      START: begin
        g_start_o = 1'b1;
        w_cnt_d   = '0;
        x_cnt_d   = '0;
        o_cnt_d   = '0;
        state_d   = LOAD_W;
      end
      LOAD_W: begin
        g_qw_valid_o  = src_w_valid_i;
        src_w_ready_o = g_qw_ready_i;
        if (src_w_valid_i && g_qw_ready_i) begin
          if (w_cnt_q == LAST_ROW) begin
            w_cnt_d = '0;
            state_d = FEED_X;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      FEED_X: begin
        x_open        = (x_cnt_q < ROWS);
        g_qx_valid_o  = src_x_valid_i && x_open;
        src_x_ready_o = g_qx_ready_i && x_open;
        if (g_qx_valid_o && src_x_ready_o) begin
          if (x_cnt_q == LAST_ROW) begin
            x_cnt_d = '0;
            state_d = DRAIN;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        dst_valid_o  = g_qo_valid_i;
        g_qo_ready_o = dst_ready_i;
        dst_last_o   = (o_cnt_q == LAST_ROW) && last_tile;
        // A misnumbered row is still forwarded; the error flag is sticky until reset.
        if (g_qo_valid_i && dst_ready_i) begin
          if (g_qo_index_i != o_cnt_q) err_d = 1'b1;
          if (o_cnt_q == LAST_ROW) begin
            o_cnt_d = '0;
            state_d = NEXT;
          end else begin
            o_cnt_d = o_cnt_q + 1'b1;
          end
        end
      end
      NEXT: begin
        if (last_tile) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          tile_cnt_d = tile_cnt_q + 1'b1;
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gemv_tile_sched.sv
// Directed bench for gemv_tile_sched with a behavioural GEMV engine model on the q ports.
module tb_gemv_tile_sched;

  localparam int MS = 16;
  localparam int RW = 512;
  localparam int IW = 5;
  localparam int TW = 8;
  localparam int DRAIN_D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid_i = 1'b0;
  logic cfg_ready_o;
  logic [TW-1:0] cfg_ntiles_i = '0;
  logic busy_o, done_o, err_o;
  logic [TW-1:0] tile_cnt_o;
  logic src_w_valid_i = 1'b1;
  logic src_w_ready_o;
  logic [RW-1:0] src_w_data_i;
  logic src_x_valid_i = 1'b1;
  logic src_x_ready_o;
  logic [RW-1:0] src_x_data_i;
  logic dst_valid_o;
  logic dst_ready_i = 1'b1;
  logic [RW-1:0] dst_data_o;
  logic [IW-1:0] dst_index_o;
  logic [TW-1:0] dst_tile_o;
  logic dst_last_o;
  logic g_start_o;
  logic g_qw_valid_o;
  logic g_qw_ready_i = 1'b1;
  logic [RW-1:0] g_qw_data_o;
  logic [IW-1:0] g_qw_index_o;
  logic g_qx_valid_o;
  logic g_qx_ready_i = 1'b1;
  logic [RW-1:0] g_qx_data_o;
  logic [IW-1:0] g_qx_index_o;
  logic g_qo_valid_i;
  logic g_qo_ready_o;
  logic [RW-1:0] g_qo_data_i;
  logic [IW-1:0] g_qo_index_i;

  int vectors = 0;
  int miscompares = 0;
  int jobRows = 0, wRows = 0, xRows = 0, starts = 0, dones = 0, lastCount = 0;
  int jobTiles = 0;
  bit errExp = 1'b0;
  bit corrupt = 1'b0;
  bit randomMode = 1'b0;
  bit qoEn = 1'b1;

  logic [31:0] wTotal = '0, xTotal = '0, oTotal = '0;
  int mX = 0, mDelay = 0;
  logic [IW-1:0] mO = '0;
  bit mDrain = 1'b0;

  gemv_tile_sched dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_ntiles_i(cfg_ntiles_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .tile_cnt_o(tile_cnt_o),
    .src_w_valid_i(src_w_valid_i), .src_w_ready_o(src_w_ready_o), .src_w_data_i(src_w_data_i),
    .src_x_valid_i(src_x_valid_i), .src_x_ready_o(src_x_ready_o), .src_x_data_i(src_x_data_i),
    .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i), .dst_data_o(dst_data_o),
    .dst_index_o(dst_index_o), .dst_tile_o(dst_tile_o), .dst_last_o(dst_last_o),
    .g_start_o(g_start_o),
    .g_qw_valid_o(g_qw_valid_o), .g_qw_ready_i(g_qw_ready_i), .g_qw_data_o(g_qw_data_o), .g_qw_index_o(g_qw_index_o),
    .g_qx_valid_o(g_qx_valid_o), .g_qx_ready_i(g_qx_ready_i), .g_qx_data_o(g_qx_data_o), .g_qx_index_o(g_qx_index_o),
    .g_qo_valid_i(g_qo_valid_i), .g_qo_ready_o(g_qo_ready_o), .g_qo_data_i(g_qo_data_i), .g_qo_index_i(g_qo_index_i)
  );

  always #5 clk = ~clk;

  assign src_w_data_i = {MS{32'hA000_0000 + wTotal}};
  assign src_x_data_i = {MS{32'hB000_0000 + xTotal}};
  assign g_qo_data_i  = {MS{32'hC000_0000 + oTotal}};
  assign g_qo_valid_i = mDrain && qoEn;
  assign g_qo_index_i = (corrupt && mO == IW'(5)) ? IW'(6) : mO;

  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: after the 16th x row it waits DRAIN_D cycles, then offers 16 output rows.
  always @(posedge clk) begin
    if (rst) begin
      mX <= 0; mDelay <= 0; mO <= '0; mDrain <= 1'b0;
    end else begin
      if (g_qx_valid_o && g_qx_ready_i) begin
        if (mX == MS - 1) begin mX <= 0; mDelay <= DRAIN_D; end
        else mX <= mX + 1;
      end
      if (mDelay != 0) begin
        mDelay <= mDelay - 1;
        if (mDelay == 1) mDrain <= 1'b1;
      end
      if (g_qo_valid_i && g_qo_ready_o) begin
        if (mO == IW'(MS - 1)) begin mO <= '0; mDrain <= 1'b0; end
        else mO <= mO + 1'b1;
      end
    end
    if (src_w_valid_i && src_w_ready_o) wTotal <= wTotal + 1;
    if (src_x_valid_i && src_x_ready_o) xTotal <= xTotal + 1;
    if (g_qo_valid_i && g_qo_ready_o) oTotal <= oTotal + 1;
  end

  // Handshake monitor, sampled mid-cycle so every value is settled before the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (g_qw_valid_o && g_qw_ready_i) begin
        checkOutput("qw_idx", RW'(g_qw_index_o), RW'(wRows % MS));
        checkOutput("qw_data", g_qw_data_o, {MS{32'hA000_0000 + wTotal}});
        checkOutput("w_ready", RW'(src_w_ready_o), RW'(1));
        wRows++;
      end
      if (g_qx_valid_o && g_qx_ready_i) begin
        checkOutput("qx_idx", RW'(g_qx_index_o), RW'(xRows % MS));
        checkOutput("qx_data", g_qx_data_o, {MS{32'hB000_0000 + xTotal}});
        xRows++;
      end
      if (dst_valid_o && dst_ready_i) begin
        checkOutput("dst_idx", RW'(dst_index_o), RW'(jobRows % MS));
        checkOutput("dst_tile", RW'(dst_tile_o), RW'(jobRows / MS));
        checkOutput("dst_last", RW'(dst_last_o), RW'(jobRows == jobTiles * MS - 1));
        checkOutput("dst_data", dst_data_o, {MS{32'hC000_0000 + oTotal}});
        checkOutput("err_run", RW'(err_o), RW'(errExp));
        if (corrupt && (jobRows % MS) == 5) errExp = 1'b1;
        if (dst_last_o) lastCount++;
        jobRows++;
      end
      if (g_start_o) starts++;
      if (done_o) dones++;
    end
  end

  task automatic applyStimulus(input int n);
    @(posedge clk); #1;
    jobRows = 0; wRows = 0; xRows = 0; starts = 0; dones = 0; lastCount = 0;
    jobTiles = n;
    cfg_ntiles_i = TW'(n);
    cfg_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("cfg_ready", RW'(cfg_ready_o), RW'(1));
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic setEnables(input bit rnd);
    src_w_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    src_x_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    g_qw_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    g_qx_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    dst_ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    qoEn          = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic waitDone(input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(posedge clk); #1;
      setEnables(randomMode);
      @(negedge clk);
      if (done_o) got = 1'b1;
    end
    checkOutput("done_seen", RW'(got), RW'(1));
    @(posedge clk); #1;
    setEnables(1'b0);
    @(negedge clk);
  endtask

  task automatic checkJob(input int n, input bit expErr);
    checkOutput("starts", RW'(starts), RW'(n));
    checkOutput("w_rows", RW'(wRows), RW'(n * MS));
    checkOutput("x_rows", RW'(xRows), RW'(n * MS));
    checkOutput("dst_rows", RW'(jobRows), RW'(n * MS));
    checkOutput("last_count", RW'(lastCount), RW'(1));
    checkOutput("done_count", RW'(dones), RW'(1));
    checkOutput("busy_end", RW'(busy_o), RW'(0));
    checkOutput("done_end", RW'(done_o), RW'(0));
    checkOutput("err_end", RW'(err_o), RW'(expErr));
    checkOutput("tile_cnt_end", RW'(tile_cnt_o), RW'(n - 1));
  endtask

  initial begin
    bit reached;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cfg_ready", RW'(cfg_ready_o), RW'(1));
    checkOutput("rst_busy", RW'(busy_o), RW'(0));
    checkOutput("rst_done", RW'(done_o), RW'(0));
    checkOutput("rst_err", RW'(err_o), RW'(0));
    checkOutput("rst_tile", RW'(tile_cnt_o), RW'(0));
    checkOutput("rst_start", RW'(g_start_o), RW'(0));
    checkOutput("rst_valids", RW'({g_qw_valid_o, g_qx_valid_o, dst_valid_o}), RW'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single tile job");
    applyStimulus(1);
    waitDone(500);
    checkJob(1, 1'b0);

    $display("[TB] three tile job");
    applyStimulus(3);
    waitDone(1000);
    checkJob(3, 1'b0);

    $display("[TB] empty job");
    applyStimulus(0);
    @(negedge clk);
    checkOutput("empty_done", RW'(done_o), RW'(1));
    @(negedge clk);
    checkOutput("empty_done_drop", RW'(done_o), RW'(0));
    checkOutput("empty_busy", RW'(busy_o), RW'(0));
    checkOutput("empty_traffic", RW'(starts + wRows + xRows + jobRows), RW'(0));
    checkOutput("empty_done_count", RW'(dones), RW'(1));

    $display("[TB] random gaps, two tiles");
    randomMode = 1'b1;
    applyStimulus(2);
    waitDone(4000);
    randomMode = 1'b0;
    checkJob(2, 1'b0);

    $display("[TB] output index 5 returned as 6");
    corrupt = 1'b1;
    applyStimulus(1);
    waitDone(500);
    corrupt = 1'b0;
    checkJob(1, 1'b1);

    $display("[TB] reset during drain of tile 1");
    applyStimulus(2);
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (jobRows >= MS + 5) reached = 1'b1;
    end
    checkOutput("drain_reached", RW'(reached), RW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_busy", RW'(busy_o), RW'(0));
    checkOutput("mid_rst_cfg_ready", RW'(cfg_ready_o), RW'(1));
    checkOutput("mid_rst_valids", RW'({g_qw_valid_o, g_qx_valid_o, dst_valid_o, g_start_o}), RW'(0));
    checkOutput("mid_rst_err", RW'(err_o), RW'(0));
    checkOutput("mid_rst_tile", RW'(tile_cnt_o), RW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    errExp = 1'b0;
    applyStimulus(1);
    waitDone(500);
    checkJob(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
